// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared widths, FSM state type and accumulator limits for neuron_mac
package neuron_pkg;
  localparam int DEF_X_W   = 5;
  localparam int DEF_W_W   = 6;
  localparam int DEF_ACC_W = 12;

  localparam logic signed [DEF_ACC_W-1:0] ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
  localparam logic signed [DEF_ACC_W-1:0] ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/neuron_mac_sat_add.sv
// rtl/neuron_mac_sat_add.sv - sat_add: accumulator plus signed addend, reduced to ACC_W bits
// NEURON_MAC_SAT_EN selects clamping to the ACC_W signed range; otherwise modulo wrap.
module sat_add #(
  parameter int ACC_W = 12,
  parameter int P_W   = 12
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [P_W-1:0]   b,
  output logic signed [ACC_W-1:0] y
);
`ifdef NEURON_MAC_SAT_EN
  localparam int SW = ACC_W + 1;

  logic signed [SW-1:0] sum;
  assign sum = SW'(a) + SW'(b);

  // Top two bits disagree exactly when the sum left the ACC_W range.
  always_comb begin
    y = sum[ACC_W-1:0];
    if (sum[SW-1] != sum[SW-2])
      y = sum[SW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  assign y = a + ACC_W'(b);
`endif
endmodule

// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - sequential MAC neuron front-end: bias + sum of x*w over N_INPUTS beats
// Build option NEURON_MAC_SAT_EN enables saturating accumulation.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int X_W      = DEF_X_W,
  parameter int W_W      = DEF_W_W,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [ACC_W-1:0] bias_in,
  input  logic        [X_W-1:0]   x_in,
  input  logic signed [W_W-1:0]   w_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    busy,
  output logic signed [ACC_W-1:0] sum_out,
  output logic                    sum_valid
);
  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int P_W   = X_W + 1 + W_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic        [CNT_W-1:0] cnt;
  logic signed [X_W:0]     x_s;
  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] acc_next;

  // Activation is unsigned: a zero MSB makes it a non-negative signed operand.
  assign x_s  = $signed({1'b0, x_in});
  assign prod = P_W'(x_s) * P_W'(w_in);

  sat_add #(.ACC_W(ACC_W), .P_W(P_W)) u_sat_add (
    .a (acc),
    .b (prod),
    .y (acc_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= bias_in;
            cnt      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid && in_ready) begin
            acc <= acc_next;
            if (cnt == LAST) begin
              sum_out   <= acc_next;
              sum_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          in_ready <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_mac.sv
// tb/tb_neuron_mac.sv - directed self-checking bench for neuron_mac (both NEURON_MAC_SAT_EN builds)
module tb_neuron_mac;
  logic               clk;
  logic               rst_n;
  logic               start;
  logic signed [11:0] bias_in;
  logic        [4:0]  x_in;
  logic signed [5:0]  w_in;
  logic               in_valid;
  logic               in_ready;
  logic               busy;
  logic signed [11:0] sum_out;
  logic               sum_valid;

  int checks = 0;
  int errors = 0;

  neuron_mac dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bias_in   (bias_in),
    .x_in      (x_in),
    .w_in      (w_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .busy      (busy),
    .sum_out   (sum_out),
    .sum_valid (sum_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one evaluation; beat i uses xv[5i+:5], wv[6i+:6]. bp inserts idle gaps with stray starts.
  task automatic do_eval(input logic signed [11:0] bias, input logic [19:0] xv,
                         input logic [23:0] wv, input bit bp,
                         output logic signed [11:0] sum, output logic v_first, output int v_cnt);
    start = 1'b1; bias_in = bias; tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bp) begin
        for (int g = 0; g < 1 + (i % 3); g++) begin
          in_valid = 1'b0; start = 1'b1; bias_in = 12'sd999; x_in = 5'd31; w_in = 6'sd31;
          tick();
          start = 1'b0;
        end
      end
      x_in = xv[i*5 +: 5]; w_in = wv[i*6 +: 6]; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    v_first = sum_valid;
    sum = sum_out;
    v_cnt = int'(sum_valid);
    for (int k = 0; k < 3; k++) begin
      tick();
      v_cnt += int'(sum_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; bias_in = 12'sd100; x_in = 5'd3; w_in = 6'sd3;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (sum_out !== 12'sd0) begin errors++; $display("FAIL reset_sum_out got %0d want 0", sum_out); end
      checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL reset_sum_valid got %b want 0", sum_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    end
    start = 1'b0; in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic signed [11:0] s; logic vf; int vc;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready got %b want 0", in_ready); end
    do_eval(12'sd0, {5'd4, 5'd3, 5'd2, 5'd1}, {6'sd1, 6'sd1, 6'sd1, 6'sd1}, 1'b0, s, vf, vc);
    checks++; if (s !== 12'sd10) begin errors++; $display("FAIL basic_sum got %0d want 10", s); end
    checks++; if (vf !== 1'b1) begin errors++; $display("FAIL basic_latency got %b want 1", vf); end
    checks++; if (vc != 1) begin errors++; $display("FAIL basic_valid_width got %0d want 1", vc); end
    checks++; if (sum_out !== 12'sd10) begin errors++; $display("FAIL basic_hold got %0d want 10", sum_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", busy); end
  endtask

  task automatic test_neg_overflow();
    logic signed [11:0] s; logic vf; int vc; logic signed [11:0] exp_s;
`ifdef NEURON_MAC_SAT_EN
    exp_s = -12'sd2048;
`else
    exp_s = 12'sd128;
`endif
    do_eval(12'sd0, {4{5'd31}}, {4{6'b100000}}, 1'b0, s, vf, vc);
    checks++; if (s !== exp_s) begin errors++; $display("FAIL neg_overflow_sum got %0d want %0d", s, exp_s); end
    checks++; if (vc != 1) begin errors++; $display("FAIL neg_overflow_valid got %0d want 1", vc); end
  endtask

  task automatic test_pos_overflow();
    logic signed [11:0] s; logic vf; int vc; logic signed [11:0] exp_s;
`ifdef NEURON_MAC_SAT_EN
    exp_s = 12'sd2047;
`else
    exp_s = -12'sd1095;
`endif
    do_eval(12'sd2040, {5'd0, 5'd0, 5'd0, 5'd31}, {6'sd0, 6'sd0, 6'sd0, 6'sd31}, 1'b0, s, vf, vc);
    checks++; if (s !== exp_s) begin errors++; $display("FAIL pos_overflow_sum got %0d want %0d", s, exp_s); end
    checks++; if (vf !== 1'b1) begin errors++; $display("FAIL pos_overflow_latency got %b want 1", vf); end
  endtask

  task automatic test_backpressure();
    logic signed [11:0] s; logic vf; int vc;
    do_eval(12'sd0, {5'd4, 5'd3, 5'd2, 5'd1}, {6'sd1, 6'sd1, 6'sd1, 6'sd1}, 1'b1, s, vf, vc);
    checks++; if (s !== 12'sd10) begin errors++; $display("FAIL backpressure_sum got %0d want 10", s); end
    checks++; if (vf !== 1'b1) begin errors++; $display("FAIL backpressure_latency got %b want 1", vf); end
    checks++; if (vc != 1) begin errors++; $display("FAIL backpressure_valid got %0d want 1", vc); end
  endtask

  task automatic test_idle_ignore();
    int vc;
    vc = 0;
    in_valid = 1'b1; x_in = 5'd7; w_in = 6'sd7;
    for (int c = 0; c < 3; c++) begin
      tick();
      vc += int'(sum_valid) + int'(busy) + int'(in_ready);
    end
    in_valid = 1'b0;
    checks++; if (vc != 0) begin errors++; $display("FAIL idle_valid_ignored got %0d want 0", vc); end
    checks++; if (sum_out !== 12'sd10) begin errors++; $display("FAIL idle_sum_hold got %0d want 10", sum_out); end
  endtask

  task automatic test_reset_mid();
    logic signed [11:0] s; logic vf; int vc;
    start = 1'b1; bias_in = 12'sd0; tick();
    start = 1'b0;
    x_in = 5'd1; w_in = 6'sd1; in_valid = 1'b1; tick();
    x_in = 5'd2; tick();
    in_valid = 1'b0; rst_n = 1'b0; tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
    checks++; if (sum_out !== 12'sd0) begin errors++; $display("FAIL midreset_sum_out got %0d want 0", sum_out); end
    rst_n = 1'b1;
    vc = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      vc += int'(sum_valid);
    end
    checks++; if (vc != 0) begin errors++; $display("FAIL midreset_no_valid got %0d want 0", vc); end
    do_eval(12'sd5, {4{5'd1}}, {4{6'sd2}}, 1'b0, s, vf, vc);
    checks++; if (s !== 12'sd13) begin errors++; $display("FAIL midreset_new_sum got %0d want 13", s); end
    checks++; if (vc != 1) begin errors++; $display("FAIL midreset_new_valid got %0d want 1", vc); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; bias_in = '0; x_in = '0; w_in = '0;
    test_reset();
    test_basic();
    test_idle_ignore();
    test_neg_overflow();
    test_pos_overflow();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
